player_uart_tx: RTL

- Serialises the 8-bit player status byte (lane, projectile bits, reset flag) from the player controller onto a single UART TX line, 8N1, LSB first.
- Sits directly downstream of the player controller and drives the board's UART TX pin toward the game host.
- Sends a frame whenever the byte changes, plus a periodic keepalive resend.
- Newest value always wins; intermediate values that change during a frame are not queued.

---
 rtl/player_uart_pkg.sv | 16 +
 rtl/uart_bit_timer.sv | 44 ++++
 rtl/player_uart_tx.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/player_uart_pkg.sv
// Shared definitions for the player status UART transmitter.
// Contents: FSM state encoding, line idle level, data width and default baud divisor.
package player_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic        UART_IDLE_LEVEL      = 1'b1;
  localparam int unsigned UART_DATA_BITS       = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap cycle.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   enable            - count while high; counter is held at 0 while low
//   bit_tick          - registered, high during the last cycle of each bit period
//   bit_tick_next_c   - combinational look-ahead: bit_tick will be high next cycle
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_tick,
  output logic bit_tick_next_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // Next count value and look-ahead of the wrap cycle
  always_comb begin
    count_next      = '0;
    bit_tick_next_c = 1'b0;
    if (enable) begin
      count_next      = (count == CNT_LAST) ? '0 : count + CNT_W'(1);
      bit_tick_next_c = (count_next == CNT_LAST);
    end
  end

  // Counter and registered tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      bit_tick <= 1'b0;
    end else begin
      count    <= count_next;
      bit_tick <= bit_tick_next_c;
    end
  end

endmodule

// File: rtl/player_uart_tx.sv
// Player status UART transmitter: sends the status byte 8N1, LSB first, whenever it
// changes and as a periodic keepalive. Newest value wins; mid-frame changes are not queued.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   data_in     - player status byte, sampled every rising edge
//   tx          - UART serial line, idles high
//   busy        - high while start, data or stop bit is on the line
//   frame_done  - one-cycle pulse during the final cycle of each stop bit
module player_uart_tx
  import player_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT     = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned KEEPALIVE_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned BIT_W  = $clog2(UART_DATA_BITS);
  localparam int unsigned KA_W   = (KEEPALIVE_CYCLES > 1) ? $clog2(KEEPALIVE_CYCLES) : 1;
  localparam int unsigned KA_MAX = (KEEPALIVE_CYCLES > 0) ? KEEPALIVE_CYCLES - 1 : 0;
  localparam logic        KA_EN  = (KEEPALIVE_CYCLES != 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  state_t            state, state_n;
  logic [7:0]        shift, shift_n;
  logic [7:0]        last_sent, last_n;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [KA_W-1:0]   ka_cnt, ka_n;
  logic              tx_n, busy_n, frame_done_n;

  logic              change, ka_hit;
  logic [7:0]        load_byte;
  logic              bit_tick, bit_tick_next_c;

  // Baud timer runs for the whole frame and rests at 0 in IDLE
  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk             (clk),
    .rst             (rst),
    .enable          (state != IDLE),
    .bit_tick        (bit_tick),
    .bit_tick_next_c (bit_tick_next_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    shift_n      = shift;
    last_n       = last_sent;
    bit_cnt_n    = bit_cnt;
    ka_n         = '0;
    tx_n         = tx;
    busy_n       = busy;
    frame_done_n = 1'b0;

    change    = (data_in != last_sent);
    ka_hit    = KA_EN && (ka_cnt == KA_W'(KA_MAX));
    load_byte = change ? data_in : last_sent;

    case (state)
      IDLE: begin
        tx_n   = UART_IDLE_LEVEL;
        busy_n = 1'b0;
        if (change || ka_hit) begin
          // tx falls on the same edge that sees the trigger
          shift_n   = load_byte;
          last_n    = load_byte;
          state_n   = START;
          tx_n      = ~UART_IDLE_LEVEL;
          busy_n    = 1'b1;
        end else if (KA_EN) begin
          ka_n = ka_cnt + KA_W'(1);
        end
      end
      START: begin
        if (bit_tick) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_n      = shift[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == BIT_LAST) begin
            state_n = STOP;
            tx_n    = UART_IDLE_LEVEL;
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift[1];
            bit_cnt_n = bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        // Pulse lands on the cycle where the timer wraps
        frame_done_n = bit_tick_next_c;
        if (bit_tick) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          tx_n    = UART_IDLE_LEVEL;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = UART_IDLE_LEVEL;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shift      <= '0;
      last_sent  <= 8'h00;
      bit_cnt    <= '0;
      ka_cnt     <= '0;
      tx         <= UART_IDLE_LEVEL;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      last_sent  <= last_n;
      bit_cnt    <= bit_cnt_n;
      ka_cnt     <= ka_n;
      tx         <= tx_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

endmodule
